// File: rtl/umi_tx_arbiter.sv
// umi_tx_arbiter: shares one UMI TX sink among N requesters.
// Round-robin arbitration with a per-owner burst limit; the winning packet is
// registered into a single output slot that stays stable until the sink takes it.
module umi_tx_arbiter #(
  parameter int N        = 4,
  parameter int DW       = 256,
  parameter int MAXBURST = 4,
  parameter int IW       = $clog2(N)
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_packet,
  output logic [N-1:0]    req_ready,
  output logic            tx_valid,
  output logic [DW-1:0]   tx_packet,
  input  logic            tx_ready,
  output logic [IW-1:0]   grant_id,
  output logic            busy
);

  // Burst counter holds 0..MAXBURST-1; it never needs to reach MAXBURST.
  localparam int            BW         = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAXBURST - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] rr_ptr;
  logic [BW-1:0] burst_cnt;
  logic [IW-1:0] win_id;
  logic [IW-1:0] scan_id;
  logic [N-1:0]  sel_ready;
  logic          accept;
  logic          win;
  logic          keep_owner;

  // Arbitration: pick the winner for this accept slot and the next FSM state
  always_comb begin
    state_nxt  = state;
    win        = 1'b0;
    keep_owner = 1'b0;
    win_id     = grant_id;
    scan_id    = '0;
    sel_ready  = '0;
    accept     = (state == IDLE) || tx_ready;
    if (accept) begin
      if ((state == BUSY) && req_valid[grant_id] && (burst_cnt < BURST_LAST)) begin
        // Current owner still has burst budget left
        win        = 1'b1;
        keep_owner = 1'b1;
        win_id     = grant_id;
      end else begin
        // Scan from rr_ptr upward with wrap; descending loop so the
        // nearest valid requester is the last (and final) assignment.
        for (int k = N - 1; k >= 0; k--) begin
          scan_id = IW'((int'(rr_ptr) + k) % N);
          if (req_valid[scan_id]) begin
            win    = 1'b1;
            win_id = scan_id;
          end
        end
      end
      state_nxt = win ? BUSY : IDLE;
    end
    if (win) begin
      sel_ready[win_id] = 1'b1;
    end
  end

  // Accept strobe is forced low while reset is held
  assign req_ready = nreset ? sel_ready : '0;
  assign tx_valid  = (state == BUSY);
  assign busy      = tx_valid;

  // FSM state register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Output slot: load the winner's packet and index; hold otherwise
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tx_packet <= '0;
      grant_id  <= '0;
    end else if (win) begin
      tx_packet <= req_packet[int'(win_id) * DW +: DW];
      grant_id  <= win_id;
    end
  end

  // Fairness bookkeeping: burst length and round-robin start point
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else if (win) begin
      if (keep_owner) begin
        burst_cnt <= burst_cnt + 1'b1;
      end else begin
        burst_cnt <= '0;
        rr_ptr    <= IW'((int'(win_id) + 1) % N);
      end
    end
  end

  // Protocol checks for simulation
  a_ready_onehot : assert property (@(posedge clk) disable iff (!nreset)
    $onehot0(req_ready));
  a_slot_stable : assert property (@(posedge clk) disable iff (!nreset)
    (tx_valid && !tx_ready) |=> ($stable(tx_packet) && $stable(grant_id)));

endmodule
